hwce_sop_sched: RTL

- Sequencer for the 4-DSP sum-of-products datapath.
- Latches a job configuration: taps per output, output count, precision.
- Meters x/w beats from the line-buffer stream into the SOP, drives its enable, clear and first-tap controls, and tracks each output's last tap through the fixed SOP pipeline.
- Presents completed outputs downstream with valid/ready back-pressure, which stalls the whole SOP pipe.

---
 rtl/hwce_sop_sched_pkg.sv | 22 ++
 rtl/hwce_sop_sched_tagpipe.sv | 38 +++
 rtl/hwce_sop_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hwce_sop_sched_pkg.sv
// Shared types and defaults for the SOP sequencer: FSM states, latched job config,
// default pipeline depth and config field widths.
package hwce_sop_sched_pkg;

  localparam int SOP_PIPE_STAGES_DEF = 4;
  localparam int CFG_FS_W            = 8;
  localparam int CFG_NOUT_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [CFG_FS_W-1:0]   fs;
    logic [CFG_NOUT_W-1:0] nout;
    logic                  prec8;
  } cfg_t;

endpackage

// File: rtl/hwce_sop_sched_tagpipe.sv
// Enable-gated, clearable shift register that walks each output's last-tap flag
// alongside the SOP datapath so its exit marks a finished accumulation.
module hwce_sop_sched_tagpipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage_d[gi] = din;
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage_q <= '0;
    end else if (en) begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/hwce_sop_sched.sv
// Job sequencer for the 4-DSP sum-of-products datapath with output back-pressure.
// Optional stall counter is built only when HWCE_SOP_SCHED_PERF_EN is defined.
module hwce_sop_sched
  import hwce_sop_sched_pkg::*;
#(
  parameter int PIPE_STAGES_SOP = SOP_PIPE_STAGES_DEF,
  parameter int FS_WIDTH        = CFG_FS_W,
  parameter int NOUT_WIDTH      = CFG_NOUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FS_WIDTH-1:0]   cfg_fs,
  input  logic [NOUT_WIDTH-1:0] cfg_nout,
  input  logic                  cfg_prec8,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sop_enable,
  output logic                  sop_clear,
  output logic                  sop_valid_x,
  output logic                  sop_first,
  output logic                  sop_prec8,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NOUT_WIDTH-1:0] out_idx,
  output logic [31:0]           perf_stall_cnt
);

  state_e                state_q, state_d;
  cfg_t                  cfg_q, cfg_d;
  logic [CFG_FS_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic [CFG_NOUT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CFG_NOUT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CFG_NOUT_W-1:0] out_idx_q, out_idx_d;
  logic                  err_q, err_d;

  logic tag_out, stall, xfer, idle, cfg_ok, start_ok, start_bad, abort_act, last_beat;

  assign idle      = (state_q == ST_IDLE);
  assign cfg_ok    = (cfg_fs != '0) && (cfg_nout != '0);
  assign start_ok  = idle && start && !abort && cfg_ok;
  assign start_bad = idle && start && !abort && !cfg_ok;
  assign abort_act = abort && !idle;

  // A held result freezes the entire SOP pipe, upstream issue included.
  assign stall       = tag_out && !out_ready;
  assign xfer        = tag_out && out_ready;
  assign in_ready    = (state_q == ST_RUN) && !stall;
  assign sop_valid_x = in_valid && in_ready;
  assign sop_first   = sop_valid_x && (tap_cnt_q == '0);
  assign last_beat   = sop_valid_x && (tap_cnt_q == cfg_q.fs - CFG_FS_W'(1));

  assign sop_enable = !stall;
  assign sop_clear  = start_ok || abort_act;
  assign sop_prec8  = cfg_q.prec8;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE) && !abort;
  assign err        = err_q;
  assign out_valid  = tag_out;
  assign out_idx    = NOUT_WIDTH'(out_idx_q);

  hwce_sop_sched_tagpipe #(
    .DEPTH (PIPE_STAGES_SOP)
  ) u_tagpipe (
    .clk  (clk),
    .rst  (rst),
    .en   (sop_enable),
    .clr  (abort_act),
    .din  (last_beat),
    .dout (tag_out)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    tap_cnt_d   = tap_cnt_q;
    issue_cnt_d = issue_cnt_q;
    done_cnt_d  = done_cnt_q;
    out_idx_d   = out_idx_q;
    err_d       = err_q;

    if (xfer) begin
      done_cnt_d = done_cnt_q + CFG_NOUT_W'(1);
      out_idx_d  = out_idx_q + CFG_NOUT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cfg_d.fs    = CFG_FS_W'(cfg_fs);
          cfg_d.nout  = CFG_NOUT_W'(cfg_nout);
          cfg_d.prec8 = cfg_prec8;
          tap_cnt_d   = '0;
          issue_cnt_d = '0;
          done_cnt_d  = '0;
          out_idx_d   = '0;
          err_d       = 1'b0;
          state_d     = ST_RUN;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (last_beat) begin
          tap_cnt_d   = '0;
          issue_cnt_d = issue_cnt_q + CFG_NOUT_W'(1);
          if (issue_cnt_q + CFG_NOUT_W'(1) == cfg_q.nout) begin
            state_d = ST_DRAIN;
          end
        end else if (sop_valid_x) begin
          tap_cnt_d = tap_cnt_q + CFG_FS_W'(1);
        end
      end
      ST_DRAIN: begin
        // Looking at the post-handshake count lets done follow the final transfer directly.
        if (done_cnt_d == cfg_q.nout) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort_act) begin
      state_d     = ST_IDLE;
      tap_cnt_d   = '0;
      issue_cnt_d = '0;
      done_cnt_d  = '0;
      out_idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      tap_cnt_q   <= '0;
      issue_cnt_q <= '0;
      done_cnt_q  <= '0;
      out_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      tap_cnt_q   <= tap_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      done_cnt_q  <= done_cnt_d;
      out_idx_q   <= out_idx_d;
      err_q       <= err_d;
    end
  end

`ifdef HWCE_SOP_SCHED_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_q <= '0;
    end else if (stall && busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
